adc_threshold_discriminator: RTL and testbench
==============================================

Name: adc_threshold_discriminator

Overview:
- Sits directly downstream of the ADC AXI-Stream inputs (s00/s02_axis_adc) inside the DAQ top level, one instance per ADC channel.
- Applies hysteretic threshold detection to each 16-sample parallel word.
- Forwards only words belonging to an "active" burst.
- Emits a timestamp for every burst start.
- Thresholds are written over a small config stream driven by the register map.

Parameters:
- SAMPLE_WIDTH, 16, bits per signed two's-complement sample.
- PARALLEL_SAMPLES, 16, samples per input word (tdata width = SAMPLE_WIDTH*PARALLEL_SAMPLES).
- TIMESTAMP_WIDTH, 32, width of the accepted-word counter.

Ports:
- clk  in  1  ADC-domain clock (256 MHz).
- reset  in  1  synchronous, active-high reset.
- s_axis_adc_tdata  in  SAMPLE_WIDTH*PARALLEL_SAMPLES  packed samples; sample i at bits [i*SW +: SW].
- s_axis_adc_tvalid  in  1  input word valid.
- s_axis_adc_tready  out  1  input word accepted.
- s_axis_cfg_tdata  in  2*SAMPLE_WIDTH  {threshold_low, threshold_high}; high in the LSBs.
- s_axis_cfg_tvalid  in  1  config write strobe.
- s_axis_cfg_tready  out  1  constant 1.
- m_axis_data_tdata  out  SAMPLE_WIDTH*PARALLEL_SAMPLES  forwarded word.
- m_axis_data_tvalid  out  1  forwarded word valid.
- m_axis_data_tready  in  1  downstream ready.
- m_axis_data_tlast  out  1  end of burst (0 when the optional feature is absent).
- m_axis_ts_tdata  out  TIMESTAMP_WIDTH  word index of the burst start.
- m_axis_ts_tvalid  out  1  timestamp valid.
- m_axis_ts_tready  in  1  timestamp consumer ready.
- ts_overflow  out  1  sticky flag: a timestamp was dropped.

Behaviour:
- Reset values:
  - All outputs 0.
  - s_axis_cfg_tready is 1.
  - threshold_high = 0x7FFF, threshold_low = 0x8000 (signed, so no trigger is possible).
  - State IDLE, word counter 0.
- Config:
  - Register threshold_low and threshold_high on any cycle with s_axis_cfg_tvalid.
  - New values apply to input words accepted from the following cycle onward.
  - Config is applied even in ACTIVE state.
- Input handshake: s_axis_adc_tready = !m_axis_data_tvalid || m_axis_data_tready.
  - A single output register stage, full throughput.
  - No combinational path from tvalid to tready.
- Word counter:
  - Increments by 1 on every input handshake, whether or not the word is forwarded.
  - Wraps modulo 2^TIMESTAMP_WIDTH.
  - The timestamp reported for a word is the counter value before the increment (the first word after reset is index 0).
- Per-word comparisons, all signed:
  - any_hi = OR over samples of (sample > threshold_high).
  - all_lo = AND over samples of (sample < threshold_low).
- State machine, 2 states, evaluated only on input handshake:
  - IDLE: if any_hi, go to ACTIVE. Forward the word and attempt a timestamp emit.
  - IDLE: otherwise drop the word and stay in IDLE.
  - ACTIVE: if all_lo, go to IDLE. Forward this word as the final burst word.
  - ACTIVE: otherwise forward the word and stay in ACTIVE.
  - If one word has any_hi and all_lo both true while in IDLE, any_hi wins and the block goes to ACTIVE.
- Data latency: 1 cycle from input handshake to m_axis_data_tvalid.
  - Output tdata is held stable while tvalid && !tready.
- Timestamp output is a single register.
  - When a burst starts and m_axis_ts_tvalid is 0, or m_axis_ts_tready is 1 in the same cycle: load the timestamp and set tvalid.
  - Otherwise drop the timestamp and set ts_overflow. ts_overflow is cleared only by reset.
  - Timestamp backpressure never stalls the data path.
- Reset mid-burst: state returns to IDLE, in-flight output words are discarded (tvalid 0), counter returns to 0.

Optional Feature:
- Macro: DISCRIMINATOR_TLAST_EN.
- Defined: m_axis_data_tlast = 1 on the forwarded ACTIVE->IDLE word; otherwise 0.
- Undefined: tlast is tied to 0 and no tlast register is generated.

Test Plan:
- Reset values, no config: feed 100 words with all samples 0x7FFF -> no m_axis_data_tvalid, no timestamp, counter reaches 100.
- cfg {low=0x0100, high=0x1000}:
  - Feed word idx0 all 0 -> dropped.
  - idx1 with one sample 0x1001 -> forwarded, ts=1.
  - idx2 all 0x0200 -> forwarded.
  - idx3 all 0x00FF -> forwarded (tlast=1 with the macro defined), state IDLE.
  - idx4 sample 0x1000 -> dropped (strictly greater required).
- Backpressure: hold m_axis_data_tready=0 for 5 cycles during a burst -> s_axis_adc_tready=0 after the first captured word, tdata stable, no word lost or duplicated once ready returns.
- Timestamp overflow: m_axis_ts_tready=0, two bursts starting at idx 3 and idx 10 -> ts holds 3, ts_overflow=1 after idx 10.
  - Then ready=1 -> one handshake of 3, flag stays 1.
- Negative thresholds: cfg {low=0xFF00 (-256), high=0xFF80 (-128)}, word with sample -100 -> trigger. Same thresholds, word with sample 0xFF81 (-127) -> trigger; -128 -> no trigger.
- Reset asserted for 1 cycle while ACTIVE with a valid output pending -> next cycle m_axis_data_tvalid=0, ts_overflow=0. The next any_hi word produces ts=0.

Source files
------------

// File: rtl/adc_threshold_discriminator_if.sv
// Stream bundle for adc_threshold_discriminator: ADC input, threshold config,
// forwarded data, burst-start timestamp and the sticky overflow flag.
interface adc_threshold_discriminator_if #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 16,
  parameter int TIMESTAMP_WIDTH  = 32
);
  localparam int WORD_W = SAMPLE_WIDTH * PARALLEL_SAMPLES;

  logic [WORD_W-1:0]          s_axis_adc_tdata;
  logic                       s_axis_adc_tvalid;
  logic                       s_axis_adc_tready;
  logic [2*SAMPLE_WIDTH-1:0]  s_axis_cfg_tdata;
  logic                       s_axis_cfg_tvalid;
  logic                       s_axis_cfg_tready;
  logic [WORD_W-1:0]          m_axis_data_tdata;
  logic                       m_axis_data_tvalid;
  logic                       m_axis_data_tready;
  logic                       m_axis_data_tlast;
  logic [TIMESTAMP_WIDTH-1:0] m_axis_ts_tdata;
  logic                       m_axis_ts_tvalid;
  logic                       m_axis_ts_tready;
  logic                       ts_overflow;

  modport master (
    output s_axis_adc_tdata, s_axis_adc_tvalid, s_axis_cfg_tdata, s_axis_cfg_tvalid,
           m_axis_data_tready, m_axis_ts_tready,
    input  s_axis_adc_tready, s_axis_cfg_tready, m_axis_data_tdata, m_axis_data_tvalid,
           m_axis_data_tlast, m_axis_ts_tdata, m_axis_ts_tvalid, ts_overflow
  );

  modport slave (
    input  s_axis_adc_tdata, s_axis_adc_tvalid, s_axis_cfg_tdata, s_axis_cfg_tvalid,
           m_axis_data_tready, m_axis_ts_tready,
    output s_axis_adc_tready, s_axis_cfg_tready, m_axis_data_tdata, m_axis_data_tvalid,
           m_axis_data_tlast, m_axis_ts_tdata, m_axis_ts_tvalid, ts_overflow
  );
endinterface

// File: rtl/adc_threshold_discriminator.sv
// Hysteretic burst discriminator on 16-sample ADC words with burst-start timestamps.
// Define DISCRIMINATOR_TLAST_EN to flag the closing word of each burst on tlast.
module adc_threshold_discriminator #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 16,
  parameter int TIMESTAMP_WIDTH  = 32
) (
  input  logic clk,
  input  logic reset,
  adc_threshold_discriminator_if.slave bus
);
  localparam int SW     = SAMPLE_WIDTH;
  localparam int WORD_W = SAMPLE_WIDTH * PARALLEL_SAMPLES;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic signed [SW-1:0]       thr_hi, thr_lo;
  logic [TIMESTAMP_WIDTH-1:0] word_cnt;
  logic [WORD_W-1:0]          data_p1;
  logic                       vld_p1;
  logic [TIMESTAMP_WIDTH-1:0] ts_p1;
  logic                       ts_vld_p1;
  logic                       ovf;
  logic                       adc_ready, accept;
  logic                       any_hi, all_lo;
  logic                       fwd, burst_start;

  function automatic logic signed [SW-1:0] sample_at(input logic [WORD_W-1:0] w, input int i);
    return $signed(w[i*SW +: SW]);
  endfunction

  assign adc_ready = !vld_p1 || bus.m_axis_data_tready;
  assign accept    = bus.s_axis_adc_tvalid && adc_ready;

  always_comb begin
    any_hi = 1'b0;
    all_lo = 1'b1;
    for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
      any_hi = any_hi | (sample_at(bus.s_axis_adc_tdata, i) > thr_hi);
      all_lo = all_lo & (sample_at(bus.s_axis_adc_tdata, i) < thr_lo);
    end
  end

  // IDLE checks any_hi first, so a word that is both above high and below low opens a burst
  always_comb begin
    state_nxt   = state;
    fwd         = 1'b0;
    burst_start = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (any_hi) begin
            state_nxt   = ACTIVE;
            fwd         = 1'b1;
            burst_start = 1'b1;
          end
        end
        ACTIVE: begin
          fwd = 1'b1;
          if (all_lo) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      thr_hi   <= {1'b0, {(SW-1){1'b1}}};
      thr_lo   <= {1'b1, {(SW-1){1'b0}}};
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (bus.s_axis_cfg_tvalid) {thr_lo, thr_hi} <= bus.s_axis_cfg_tdata;
      if (accept) word_cnt <= word_cnt + TIMESTAMP_WIDTH'(1);
    end
  end

  // Stage p1: output word register, refilled only when its slot is free
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (accept) vld_p1 <= fwd;
      else if (bus.m_axis_data_tready) vld_p1 <= 1'b0;
      if (accept && fwd) data_p1 <= bus.s_axis_adc_tdata;
    end
  end

  // Stage p1: timestamp register; a busy slot drops the new stamp instead of stalling data
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_vld_p1 <= 1'b0;
      ts_p1     <= '0;
      ovf       <= 1'b0;
    end else if (burst_start && (!ts_vld_p1 || bus.m_axis_ts_tready)) begin
      ts_vld_p1 <= 1'b1;
      ts_p1     <= word_cnt;
    end else begin
      if (bus.m_axis_ts_tready) ts_vld_p1 <= 1'b0;
      if (burst_start) ovf <= 1'b1;
    end
  end

`ifdef DISCRIMINATOR_TLAST_EN
  logic burst_end;
  logic last_p1;

  assign burst_end = accept && (state == ACTIVE) && all_lo;

  always_ff @(posedge clk) begin
    if (reset) last_p1 <= 1'b0;
    else if (accept) last_p1 <= burst_end;
  end

  assign bus.m_axis_data_tlast = last_p1;
`else
  assign bus.m_axis_data_tlast = 1'b0;
`endif

  assign bus.s_axis_adc_tready  = adc_ready;
  assign bus.s_axis_cfg_tready  = 1'b1;
  assign bus.m_axis_data_tdata  = data_p1;
  assign bus.m_axis_data_tvalid = vld_p1;
  assign bus.m_axis_ts_tdata    = ts_p1;
  assign bus.m_axis_ts_tvalid   = ts_vld_p1;
  assign bus.ts_overflow        = ovf;
endmodule

// File: tb/tb_adc_threshold_discriminator.sv
// Directed bench for adc_threshold_discriminator with hand-computed expectations.
module tb_adc_threshold_discriminator;
  localparam int SW = 16;
  localparam int PS = 16;
  localparam int TW = 32;
  localparam int WW = SW * PS;

`ifdef DISCRIMINATOR_TLAST_EN
  localparam logic TLAST_EXP = 1'b1;
`else
  localparam logic TLAST_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ts_hs  = 0;
  logic [WW-1:0] got[$];

  always #5 clk = ~clk;

  adc_threshold_discriminator_if #(.SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .TIMESTAMP_WIDTH(TW)) bus ();

  adc_threshold_discriminator #(.SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .TIMESTAMP_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (!rst && bus.m_axis_data_tvalid && bus.m_axis_data_tready) got.push_back(bus.m_axis_data_tdata);
    if (!rst && bus.m_axis_ts_tvalid && bus.m_axis_ts_tready) ts_hs <= ts_hs + 1;
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WW-1:0] mk(input logic [SW-1:0] fill, input int idx, input logic [SW-1:0] v);
    logic [WW-1:0] w;
    for (int i = 0; i < PS; i++) w[i*SW +: SW] = (i == idx) ? v : fill;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [SW-1:0] lo, input logic [SW-1:0] hi);
    bus.s_axis_cfg_tdata  = {lo, hi};
    bus.s_axis_cfg_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_axis_cfg_tvalid = 1'b0;
  endtask

  task automatic send(input logic [WW-1:0] w);
    bit hs;
    hs = 1'b0;
    bus.s_axis_adc_tdata  = w;
    bus.s_axis_adc_tvalid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      @(negedge clk);
      hs = bus.s_axis_adc_tready;
      @(posedge clk); #1;
    end
    bus.s_axis_adc_tvalid = 1'b0;
    if (!hs) chk("send_timeout", 0, 1);
  endtask

  initial begin
    logic [WW-1:0] w1, w2;
    bit seen_vld, seen_ts;
    int base_got, base_ts;

    bus.s_axis_adc_tdata   = '0;
    bus.s_axis_adc_tvalid  = 1'b0;
    bus.s_axis_cfg_tdata   = '0;
    bus.s_axis_cfg_tvalid  = 1'b0;
    bus.m_axis_data_tready = 1'b1;
    bus.m_axis_ts_tready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_data_vld", bus.m_axis_data_tvalid, 0);
    chk("rst_data", bus.m_axis_data_tdata, 0);
    chk("rst_last", bus.m_axis_data_tlast, 0);
    chk("rst_ts_vld", bus.m_axis_ts_tvalid, 0);
    chk("rst_ts", bus.m_axis_ts_tdata, 0);
    chk("rst_ovf", bus.ts_overflow, 0);
    chk("rst_cfg_rdy", bus.s_axis_cfg_tready, 1);

    // Default thresholds: saturated samples never trigger, but they are counted
    seen_vld = 0;
    seen_ts  = 0;
    for (int i = 0; i < 100; i++) begin
      send(mk(16'h7FFF, -1, 16'h0));
      seen_vld |= bus.m_axis_data_tvalid;
      seen_ts  |= bus.m_axis_ts_tvalid;
    end
    chk("a_no_data", seen_vld, 0);
    chk("a_no_ts", seen_ts, 0);
    cfg(16'h0100, 16'h1000);
    send(mk(16'h0, 2, 16'h1001));
    chk("a_ts_vld", bus.m_axis_ts_tvalid, 1);
    chk("a_ts_cnt100", bus.m_axis_ts_tdata, 100);
    send(mk(16'h00FF, -1, 16'h0));

    // Basic burst
    do_reset();
    cfg(16'h0100, 16'h1000);
    send(mk(16'h0, -1, 16'h0));
    chk("b0_drop", bus.m_axis_data_tvalid, 0);
    w1 = mk(16'h0, 9, 16'h1001);
    send(w1);
    chk("b1_vld", bus.m_axis_data_tvalid, 1);
    chk("b1_data", bus.m_axis_data_tdata, w1);
    chk("b1_last", bus.m_axis_data_tlast, 0);
    chk("b1_ts_vld", bus.m_axis_ts_tvalid, 1);
    chk("b1_ts", bus.m_axis_ts_tdata, 1);
    send(mk(16'h0200, -1, 16'h0));
    chk("b2_vld", bus.m_axis_data_tvalid, 1);
    chk("b2_data", bus.m_axis_data_tdata, mk(16'h0200, -1, 16'h0));
    chk("b2_ts_gone", bus.m_axis_ts_tvalid, 0);
    send(mk(16'h00FF, -1, 16'h0));
    chk("b3_vld", bus.m_axis_data_tvalid, 1);
    chk("b3_last", bus.m_axis_data_tlast, TLAST_EXP);
    send(mk(16'h0, 4, 16'h1000));
    chk("b4_eq_hi_drop", bus.m_axis_data_tvalid, 0);

    // Backpressure
    do_reset();
    cfg(16'h0100, 16'h1000);
    base_got = got.size();
    bus.m_axis_data_tready = 1'b0;
    w1 = mk(16'h0300, 0, 16'h2000);
    w2 = mk(16'h0400, 15, 16'h0411);
    send(w1);
    chk("c_vld", bus.m_axis_data_tvalid, 1);
    chk("c_rdy_low", bus.s_axis_adc_tready, 0);
    bus.s_axis_adc_tdata  = w2;
    bus.s_axis_adc_tvalid = 1'b1;
    seen_vld = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.m_axis_data_tdata !== w1 || !bus.m_axis_data_tvalid || bus.s_axis_adc_tready) seen_vld = 0;
    end
    chk("c_hold_stable", seen_vld, 1);
    bus.m_axis_data_tready = 1'b1;
    @(posedge clk); #1;
    bus.s_axis_adc_tvalid = 1'b0;
    chk("c_w2_data", bus.m_axis_data_tdata, w2);
    chk("c_w2_vld", bus.m_axis_data_tvalid, 1);
    @(posedge clk); #1;
    chk("c_out_count", got.size() - base_got, 2);
    if (got.size() - base_got == 2) begin
      chk("c_out0", got[base_got], w1);
      chk("c_out1", got[base_got + 1], w2);
    end

    // Timestamp overflow
    do_reset();
    cfg(16'h0100, 16'h1000);
    bus.m_axis_ts_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(16'h0, -1, 16'h0));
    send(mk(16'h0, 0, 16'h2000));
    chk("d_ts_vld3", bus.m_axis_ts_tvalid, 1);
    chk("d_ts3", bus.m_axis_ts_tdata, 3);
    chk("d_ovf0", bus.ts_overflow, 0);
    for (int i = 4; i < 10; i++) send(mk(16'h0, -1, 16'h0));
    send(mk(16'h0, 0, 16'h2000));
    chk("d_ts_hold3", bus.m_axis_ts_tdata, 3);
    chk("d_ovf1", bus.ts_overflow, 1);
    base_ts = ts_hs;
    bus.m_axis_ts_tready = 1'b1;
    @(posedge clk); #1;
    chk("d_ts_hs1", ts_hs - base_ts, 1);
    chk("d_ts_drained", bus.m_axis_ts_tvalid, 0);
    chk("d_ovf_sticky", bus.ts_overflow, 1);

    // Reset in the middle of a burst with a word pending
    bus.m_axis_data_tready = 1'b0;
    send(mk(16'h0500, -1, 16'h0));
    chk("e_pending", bus.m_axis_data_tvalid, 1);
    do_reset();
    chk("e_vld_clr", bus.m_axis_data_tvalid, 0);
    chk("e_ovf_clr", bus.ts_overflow, 0);
    bus.m_axis_data_tready = 1'b1;
    cfg(16'h0100, 16'h1000);
    send(mk(16'h0, 6, 16'h7000));
    chk("e_ts_vld", bus.m_axis_ts_tvalid, 1);
    chk("e_ts0", bus.m_axis_ts_tdata, 0);

    // Negative thresholds, signed compare
    do_reset();
    cfg(16'hFF00, 16'hFF80);
    send(mk(16'hFE00, 3, 16'hFF9C));
    chk("f_m100_trig", bus.m_axis_data_tvalid, 1);
    send(mk(16'hFE00, -1, 16'h0));
    chk("f_end_vld", bus.m_axis_data_tvalid, 1);
    chk("f_end_last", bus.m_axis_data_tlast, TLAST_EXP);
    send(mk(16'hFE00, 5, 16'hFF81));
    chk("f_m127_trig", bus.m_axis_data_tvalid, 1);
    send(mk(16'hFE00, -1, 16'h0));
    send(mk(16'hFE00, 7, 16'hFF80));
    chk("f_m128_drop", bus.m_axis_data_tvalid, 0);

    // Word both above high and below low: starts a burst from IDLE, ends it from ACTIVE
    cfg(16'h1000, 16'h0000);
    send(mk(16'h0010, -1, 16'h0));
    chk("g_start_vld", bus.m_axis_data_tvalid, 1);
    chk("g_start_last", bus.m_axis_data_tlast, 0);
    send(mk(16'h0010, -1, 16'h0));
    chk("g_end_vld", bus.m_axis_data_tvalid, 1);
    chk("g_end_last", bus.m_axis_data_tlast, TLAST_EXP);
    send(mk(16'h0010, -1, 16'h0));
    chk("g_restart_last", bus.m_axis_data_tlast, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
